// File: rtl/block_accumulator_if.sv
// Row-stream interface between the block multiplier, the tile accumulator and the result writer.
interface block_accumulator_if #(
  parameter int unsigned BIT_WIDTH = 16
);
  logic [4*BIT_WIDTH-1:0] row0;
  logic [4*BIT_WIDTH-1:0] row1;
  logic [4*BIT_WIDTH-1:0] row2;
  logic [4*BIT_WIDTH-1:0] row3;
  logic                   done;
  logic [4*BIT_WIDTH-1:0] out_row;
  logic [1:0]             out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [3:0]             k_idx;
  logic                   busy;
  logic                   drop_err;

  modport master (
    output row0, row1, row2, row3, done, out_ready,
    input  out_row, out_idx, out_valid, out_last, k_idx, busy, drop_err
  );

  modport slave (
    input  row0, row1, row2, row3, done, out_ready,
    output out_row, out_idx, out_valid, out_last, k_idx, busy, drop_err
  );
endinterface

// File: rtl/block_accumulator.sv
// Sums NUM_K 4x4 partial products into one tile, then streams the tile out one row per cycle.
module block_accumulator #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 8,
  parameter int unsigned NUM_K      = 4
) (
  input logic                clk,
  input logic                rst,
  block_accumulator_if.slave bus
);

  localparam int unsigned RowWidth = 4 * BIT_WIDTH;

  if (NUM_K == 0 || NUM_K > 16 || FRAC_WIDTH >= BIT_WIDTH) begin : gen_bad_params
    $error("block_accumulator: illegal parameter combination");
  end

  typedef enum logic {StAccum, StDrain} state_e;

  state_e              state_q, state_d;
  logic [RowWidth-1:0] acc_q [4];
  logic [RowWidth-1:0] acc_d [4];
  logic [RowWidth-1:0] rows  [4];
  logic [3:0]          k_cnt_q, k_cnt_d;
  logic [1:0]          row_cnt_q, row_cnt_d;
  logic                done_q;
  logic                drop_err_q, drop_err_d;
  logic                take;

  assign rows[0] = bus.row0;
  assign rows[1] = bus.row1;
  assign rows[2] = bus.row2;
  assign rows[3] = bus.row3;

  // A held-high done counts once.
  assign take = bus.done & ~done_q;

  // Independent per-lane adds; each lane wraps modulo 2^BIT_WIDTH with no carry between lanes.
  function automatic logic [RowWidth-1:0] lane_add(input logic [RowWidth-1:0] a,
                                                   input logic [RowWidth-1:0] b);
    logic [RowWidth-1:0] sum;
    for (int l = 0; l < 4; l++) begin
      sum[l*BIT_WIDTH +: BIT_WIDTH] = a[l*BIT_WIDTH +: BIT_WIDTH] + b[l*BIT_WIDTH +: BIT_WIDTH];
    end
    return sum;
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    k_cnt_d    = k_cnt_q;
    row_cnt_d  = row_cnt_q;
    drop_err_d = drop_err_q;
    unique case (state_q)
      StAccum: begin
        if (take) begin
          for (int r = 0; r < 4; r++) begin
            acc_d[r] = (k_cnt_q == 4'd0) ? rows[r] : lane_add(acc_q[r], rows[r]);
          end
          if (k_cnt_q == 4'(NUM_K - 1)) begin
            k_cnt_d   = 4'd0;
            row_cnt_d = 2'd0;
            state_d   = StDrain;
          end else begin
            k_cnt_d = k_cnt_q + 4'd1;
          end
        end
      end
      StDrain: begin
        // Tile is frozen while draining; a new product here is lost.
        if (take) begin
          drop_err_d = 1'b1;
        end
        if (bus.out_ready) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) begin
            state_d = StAccum;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAccum;
      k_cnt_q    <= 4'd0;
      row_cnt_q  <= 2'd0;
      done_q     <= 1'b0;
      drop_err_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      row_cnt_q  <= row_cnt_d;
      done_q     <= bus.done;
      drop_err_q <= drop_err_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.out_valid = (state_q == StDrain);
  assign bus.busy      = (state_q == StDrain);
  assign bus.out_row   = acc_q[row_cnt_q];
  assign bus.out_idx   = row_cnt_q;
  assign bus.out_last  = (state_q == StDrain) && (row_cnt_q == 2'd3);
  assign bus.k_idx     = k_cnt_q;
  assign bus.drop_err  = drop_err_q;

endmodule

// File: doc/block_accumulator.md
# block_accumulator

Downstream stage of the 4x32 block multiplier. Each multiplier `done` pulse delivers one 4x4 partial product on `row0`..`row3`. This block sums NUM_K consecutive partial products into one output tile, C_ij = sum over k of A_ik·B_kj. It then streams the finished tile out one row per cycle under a valid/ready handshake toward the result writer.

## Interface
- BIT_WIDTH, 16: width of one fixed-point element; matches the multiplier.
- FRAC_WIDTH, 8: fractional bits. Pass-through only; accumulation is a plain add, so the binary point is preserved.
- NUM_K, 4: partial products summed per output tile. Legal range 1..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- row0..row3  in  4*BIT_WIDTH each  partial-product rows from the multiplier. Element 0 is in bits [4*BIT_WIDTH-1:3*BIT_WIDTH].
- done  in  1  multiplier completion flag. May be held high for more than one cycle.
- out_row  out  4*BIT_WIDTH  accumulated row selected by out_idx, same packing as row0.
- out_idx  out  2  row index of out_row, 0..3.
- out_valid  out  1  out_row/out_idx are valid.
- out_ready  in  1  consumer accepts the current row.
- out_last  out  1  high together with out_valid when out_idx==3.
- k_idx  out  4  count of partial products absorbed into the current tile.
- busy  out  1  high while in DRAIN.
- drop_err  out  1  sticky; a partial product was dropped.

## Operation
- Rising-edge detect: `done_d` is registered. Event `take = done & ~done_d`. A multi-cycle `done` counts once.
- Storage: acc[0..3], each 4*BIT_WIDTH. Counters: k_cnt (4 b), row_cnt (2 b).
- Arithmetic: per 16-bit lane, two's-complement add with wrap-around modulo 2^BIT_WIDTH. No saturation and no carry between lanes.
- State ACCUM:
  - out_valid=0, busy=0.
  - On `take`, acc[r] is written for every r: it takes row_r when k_cnt==0 (the first product overwrites), otherwise acc[r]+row_r.
  - If k_cnt==NUM_K-1, set k_cnt<=0 and go to DRAIN with row_cnt<=0. Otherwise k_cnt<=k_cnt+1.
- State DRAIN:
  - out_valid=1, busy=1.
  - out_row=acc[row_cnt], out_idx=row_cnt, out_last=(row_cnt==3).
  - On out_valid&out_ready, row_cnt<=row_cnt+1. If row_cnt==3, go to ACCUM.
  - out_row and out_idx stay stable while out_ready=0.
- A `take` in DRAIN is discarded: acc, k_cnt and row_cnt are unchanged, and drop_err<=1. drop_err clears only on rst.
- k_idx = k_cnt. In DRAIN it reads 0.
- NUM_K=1: every `take` goes straight to DRAIN.

## Timing
- Reset values, asynchronous on rst=1:
  - state ACCUM; acc all 0; k_cnt 0; row_cnt 0; done_d 0.
  - out_valid 0, out_last 0, out_idx 0, out_row 0, k_idx 0, busy 0, drop_err 0.
- row0..row3 are sampled on the same edge at which `take`=1.
- Latency from the final `take` to the first output:
  - The edge of the final `take` enters DRAIN.
  - out_valid is high in the next cycle, carrying row 0 with the final sum included.
- Drain throughput: one row per cycle while out_ready=1. With out_ready tied high, the minimum DRAIN length is 4 cycles.
- Leaving DRAIN: the edge that accepts row 3 returns the block to ACCUM. A `take` in the cycle right after that is accepted as k=0 of the next tile.
- A `take` on the same edge as the row-3 acceptance still falls in DRAIN, so it is dropped.
- rst mid-accumulation or mid-drain discards the partial tile. The first `take` after reset starts a new tile.
- Outputs are driven only from registers and the state decode; there is no combinational path from out_ready to out_valid.

## Test plan
- Single tile: NUM_K=4. Four done pulses, each with every element 16'h0100 (1.0). Response: four rows with every lane 16'h0400, out_idx 0,1,2,3, out_last only on idx 3, drop_err=0.
- Long done: done held high for 3 cycles with rows=16'h0010. Response: k_idx advances by exactly 1; the value is counted once.
- Backpressure: out_ready=0 for 5 cycles after DRAIN entry. Response: out_valid=1, out_idx=0 and out_row stable throughout. Rows 0..3 then emerge in 4 consecutive cycles once out_ready=1.
- Wrap and sign: lane sums 16'h7F00+16'h0200 and 16'hFF00(-1.0)+16'h0080. Response: 16'h8100 and 16'hFF80, with neighbouring lanes unaffected.
- Drop: a `take` while stalled in DRAIN. Response: drop_err=1 sticky, output tile unchanged. The next tile starts with k_idx=0 after the drain.
- Reset mid-tile: rst asserted after 2 of 4 takes. Response: all outputs at their reset values immediately. A subsequent 4-take tile sums only the post-reset inputs.
